atomic_alu_sequencer: RTL and testbench

ATOMIC_ALU_SEQUENCER -- requirements
Module: atomic_alu_sequencer

---
 rtl/atomic_alu_sequencer_if.sv | 32 +++
 rtl/atomic_alu_sequencer.sv | 135 +++++++++++++
 tb/tb_atomic_alu_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/atomic_alu_sequencer_if.sv
// Command/response bundle for atomic_alu_sequencer.
// The master issues commands and consumes responses; the sequencer is the slave.
interface atomic_alu_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int REGS   = 8
);
    localparam int AW    = $clog2(REGS);
    localparam int CMD_W = 3 + 3 * AW;

    // Both channels use strict valid/ready semantics: a transfer happens on a rising
    // clk edge where valid && ready. Once valid is high, the payload is held stable and
    // valid stays high until that transfer. Valid never waits on ready.
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CMD_W-1:0]  cmd;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [3:0]        rsp_flags;
    logic              rsp_cas_ok;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_cas_ok, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_cas_ok, rsp_err
    );
endinterface

// File: rtl/atomic_alu_sequencer.sv
// Register-file sequencer driving an external combinational ALU, with optional
// compare-and-swap on opcode 7 (enabled by defining ATOMIC_CAS_EN).
module atomic_alu_sequencer #(
    parameter int DATA_W = 32,
    parameter int REGS   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    atomic_alu_sequencer_if.slave    bus,
    output logic [2:0]               alu_op_code,
    output logic [DATA_W-1:0]        data_a,
    output logic [DATA_W-1:0]        data_b,
    input  logic [DATA_W-1:0]        y,
    input  logic                     O,
    input  logic                     C,
    input  logic                     Z,
    input  logic                     N,
    input  logic [$clog2(REGS)-1:0]  dbg_addr,
    output logic [DATA_W-1:0]        dbg_data,
    output logic [1:0]               dbg_state
);
    localparam int AW    = $clog2(REGS);
    localparam int CMD_W = 3 + 3 * AW;

`ifdef ATOMIC_CAS_EN
    localparam bit CAS_EN = 1'b1;
`else
    localparam bit CAS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;

    state_t            state, state_nxt;
    logic [2:0]        op_q;
    logic [AW-1:0]     a1_q, a2_q, a3_q;
    logic [DATA_W-1:0] regs [REGS];
    logic [2:0]        cmd_op;
    logic              accept;
    logic              cmd_ready_c;
    logic              rsp_valid_c;
    logic [DATA_W-1:0] wb_data;
    logic [AW-1:0]     wb_addr;
    logic              wb_cas_ok;

    assign cmd_op        = bus.cmd[CMD_W-1 -: 3];
    assign accept        = bus.cmd_valid && cmd_ready_c;
    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rsp_valid = rsp_valid_c;
    assign dbg_data      = regs[dbg_addr];
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready_c = 1'b0;
        rsp_valid_c = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready_c = 1'b1;
                // Without CAS support opcode 7 has nothing to compute and answers at once.
                if (bus.cmd_valid)
                    state_nxt = (cmd_op == 3'd7 && !CAS_EN) ? RESP : EXEC;
            end
            EXEC: state_nxt = WB;
            WB:   state_nxt = RESP;
            RESP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single write-back target; the register file is untouched until the WB edge,
    // so every read here sees pre-write values regardless of address aliasing.
    always_comb begin
        wb_data   = y;
        wb_addr   = a3_q;
        wb_cas_ok = 1'b0;
        if (CAS_EN && op_q == 3'd7) begin
            if (Z) begin
                wb_data   = regs[a2_q];
                wb_addr   = a1_q;
                wb_cas_ok = 1'b1;
            end else begin
                wb_data   = regs[a1_q];
                wb_addr   = a3_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q           <= '0;
            a1_q           <= '0;
            a2_q           <= '0;
            a3_q           <= '0;
            alu_op_code    <= '0;
            data_a         <= '0;
            data_b         <= '0;
            bus.rsp_data   <= '0;
            bus.rsp_flags  <= '0;
            bus.rsp_cas_ok <= 1'b0;
            bus.rsp_err    <= 1'b0;
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
        end else begin
            if (accept) begin
                {op_q, a1_q, a2_q, a3_q} <= bus.cmd;
                if (cmd_op == 3'd7 && !CAS_EN) begin
                    bus.rsp_data   <= '0;
                    bus.rsp_flags  <= '0;
                    bus.rsp_cas_ok <= 1'b0;
                    bus.rsp_err    <= 1'b1;
                end
            end
            if (state == EXEC) begin
                // CAS compares reg[a1] against the expected value in reg[a3] by subtraction.
                alu_op_code <= (op_q == 3'd7) ? 3'b001 : op_q;
                data_a      <= regs[a1_q];
                data_b      <= (op_q == 3'd7) ? regs[a3_q] : regs[a2_q];
            end
            if (state == WB) begin
                regs[wb_addr]  <= wb_data;
                bus.rsp_data   <= wb_data;
                bus.rsp_flags  <= {O, C, Z, N};
                bus.rsp_cas_ok <= wb_cas_ok;
                bus.rsp_err    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_atomic_alu_sequencer.sv
// Scoreboard bench for atomic_alu_sequencer: random and directed commands against a
// register-file reference model; honours ATOMIC_CAS_EN the same way as the design.
`timescale 1ns/1ps
module tb_atomic_alu_sequencer;
    localparam int DATA_W = 32;
    localparam int REGS   = 8;
    localparam int AW     = 3;
    localparam int EXP_W  = DATA_W + 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    atomic_alu_sequencer_if #(.DATA_W(DATA_W), .REGS(REGS)) bus ();

    logic [2:0]        alu_op_code;
    logic [DATA_W-1:0] data_a, data_b, y;
    logic              O, C, Z, N;
    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic [1:0]        dbg_state;
    logic [DATA_W-1:0] alu_imm;

    atomic_alu_sequencer #(.DATA_W(DATA_W), .REGS(REGS)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_op_code(alu_op_code), .data_a(data_a), .data_b(data_b),
        .y(y), .O(O), .C(C), .Z(Z), .N(N),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] model_regs [REGS];
    bit                hold_ready = 1'b0;

    // Bench ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 load-immediate (alu_imm).
    function automatic logic [35:0] alu_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] imm);
        logic [32:0] s;
        logic [31:0] r;
        logic        o, c;
        o = 1'b0;
        c = 1'b0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                        o = (a[31] == b[31]) && (r[31] != a[31]); end
            3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = s[32];
                        o = (a[31] != b[31]) && (r[31] != a[31]); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << b[4:0];
            default: r = imm;
        endcase
        return {o, c, (r == 32'd0), r[31], r};
    endfunction

    always_comb {O, C, Z, N, y} = alu_calc(alu_op_code, data_a, data_b, alu_imm);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_issue(input logic [2:0] op, input logic [AW-1:0] a1, a2, a3,
                               input logic [31:0] imm);
        logic [35:0] r;
        logic [31:0] d;
        logic        ok;
        if (op != 3'd7) begin
            r = alu_calc(op, model_regs[a1], model_regs[a2], imm);
            model_regs[a3] = r[31:0];
            exp_q.push_back({r[31:0], r[35:32], 1'b0, 1'b0});
        end else begin
`ifdef ATOMIC_CAS_EN
            r = alu_calc(3'd1, model_regs[a1], model_regs[a3], imm);
            if (model_regs[a1] == model_regs[a3]) begin
                d = model_regs[a2];
                model_regs[a1] = d;
                ok = 1'b1;
            end else begin
                d = model_regs[a1];
                model_regs[a3] = d;
                ok = 1'b0;
            end
            exp_q.push_back({d, r[35:32], ok, 1'b0});
`else
            exp_q.push_back({32'd0, 4'd0, 1'b0, 1'b1});
`endif
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [AW-1:0] a1, a2, a3,
                         input logic [31:0] imm, input bit track);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready) begin
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL cmd_ready_timeout actual=0 required=1");
                return;
            end
            @(negedge clk);
        end
        alu_imm = imm;
        bus.cmd = {op, a1, a2, a3};
        bus.cmd_valid = 1'b1;
        if (track) model_issue(op, a1, a2, a3, imm);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] r, input logic [31:0] v);
        issue(3'd6, '0, '0, r, v, 1'b1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while (exp_q.size() != 0 || !bus.cmd_ready) begin
            n++;
            if (n > 500) begin
                checks++; errors++;
                $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
                exp_q.delete();
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < REGS; i++) begin
            @(negedge clk);
            dbg_addr = AW'(i);
            #1 check("reg_file", dbg_data, model_regs[i]);
        end
    endtask

    // Response consumer: random backpressure, updated just after each rising edge.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 bus.rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the expected queue on every response transfer.
    initial begin
        logic [EXP_W-1:0] act, held, e;
        bit               have_held;
        have_held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid) begin
                act = {bus.rsp_data, bus.rsp_flags, bus.rsp_cas_ok, bus.rsp_err};
                check("cmd_ready_in_resp", bus.cmd_ready, 64'd0);
                if (have_held) check("rsp_stable", act, held);
                if (bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp actual=%0h required=none", act);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp", act, e);
                    end
                    have_held = 1'b0;
                end else begin
                    held = act;
                    have_held = 1'b1;
                end
            end else begin
                have_held = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [EXP_W-1:0] snap;
        logic [2:0]       op;
        logic [AW-1:0]    a1, a2, a3;

        bus.cmd_valid = 1'b0;
        bus.cmd = '0;
        dbg_addr = '0;
        alu_imm = '0;
        for (int i = 0; i < REGS; i++) model_regs[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 64'd1);
        check("rst_rsp_valid", bus.rsp_valid, 64'd0);
        check("rst_rsp_data", bus.rsp_data, 64'd0);
        check("rst_rsp_flags", bus.rsp_flags, 64'd0);
        check("rst_rsp_cas_ok", bus.rsp_cas_ok, 64'd0);
        check("rst_rsp_err", bus.rsp_err, 64'd0);
        check("rst_alu_op", alu_op_code, 64'd0);
        check("rst_data_a", data_a, 64'd0);
        check("rst_data_b", data_b, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("cmd_ready_after_rst", bus.cmd_ready, 64'd1);
        check_regs();

        // Add with 3-cycle latency: 5 + 7 -> reg3 = 12
        load(3'd1, 32'd5);
        load(3'd2, 32'd7);
        wait_drain();
        issue(3'd0, 3'd1, 3'd2, 3'd3, 32'd0, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.rsp_valid && n < 10);
        check("latency", n, 64'd3);
        check("add_rsp_data", bus.rsp_data, 64'd12);
        check("add_z", bus.rsp_flags[1], 64'd0);
        wait_drain();
        @(negedge clk);
        dbg_addr = 3'd3;
        #1 check("add_reg3", dbg_data, 64'd12);

        // Backpressure: response held for 5 cycles
        hold_ready = 1'b1;
        @(posedge clk);
        issue(3'd1, 3'd2, 3'd1, 3'd4, 32'd0, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        snap = {bus.rsp_data, bus.rsp_flags, bus.rsp_cas_ok, bus.rsp_err};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", bus.rsp_valid, 64'd1);
            check("bp_cmd_ready", bus.cmd_ready, 64'd0);
            check("bp_rsp_hold", {bus.rsp_data, bus.rsp_flags, bus.rsp_cas_ok, bus.rsp_err}, snap);
        end
        hold_ready = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);
        check("bp_single_rsp", bus.rsp_valid, 64'd0);

`ifdef ATOMIC_CAS_EN
        // CAS success and failure
        load(3'd1, 32'd9);
        load(3'd3, 32'd9);
        load(3'd2, 32'h55);
        issue(3'd7, 3'd1, 3'd2, 3'd3, 32'd0, 1'b1);
        wait_drain();
        @(negedge clk); dbg_addr = 3'd1; #1 check("cas_ok_reg1", dbg_data, 64'h55);
        @(negedge clk); dbg_addr = 3'd3; #1 check("cas_ok_reg3", dbg_data, 64'd9);
        load(3'd1, 32'd9);
        load(3'd3, 32'd4);
        issue(3'd7, 3'd1, 3'd2, 3'd3, 32'd0, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cas_fail_data", bus.rsp_data, 64'd9);
        check("cas_fail_ok", bus.rsp_cas_ok, 64'd0);
        wait_drain();
        @(negedge clk); dbg_addr = 3'd3; #1 check("cas_fail_reg3", dbg_data, 64'd9);
        @(negedge clk); dbg_addr = 3'd1; #1 check("cas_fail_reg1", dbg_data, 64'd9);
`else
        // Opcode 7 rejected without touching registers
        issue(3'd7, 3'd1, 3'd2, 3'd3, 32'd0, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("op7_err", bus.rsp_err, 64'd1);
        check("op7_data", bus.rsp_data, 64'd0);
        wait_drain();
`endif
        check_regs();

        // Reset during WB aborts the command
        load(3'd1, 32'd5);
        load(3'd2, 32'd7);
        load(3'd3, 32'hA5A5);
        wait_drain();
        issue(3'd0, 3'd1, 3'd2, 3'd3, 32'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < REGS; i++) model_regs[i] = '0;
        repeat (2) @(negedge clk);
        check("abort_rsp_valid", bus.rsp_valid, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("abort_cmd_ready", bus.cmd_ready, 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rsp", bus.rsp_valid, 64'd0);
        end
        dbg_addr = 3'd3;
        #1 check("abort_reg3", dbg_data, 64'd0);

        // Random traffic with aliasing
        for (int k = 0; k < 300; k++) begin
            op = 3'($urandom_range(0, 7));
            a1 = AW'($urandom_range(0, REGS - 1));
            a2 = AW'($urandom_range(0, REGS - 1));
            a3 = AW'($urandom_range(0, REGS - 1));
            if ($urandom_range(0, 2) == 0) a3 = a1;
            issue(op, a1, a2, a3, $urandom, 1'b1);
            if (k % 100 == 99) begin
                wait_drain();
                check_regs();
            end
        end
        wait_drain();
        check_regs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
